// File: rtl/rng_word_arbiter.sv
// rng_word_arbiter: round-robin share of one rng_stream generator among NUM_REQ requesters.
// Latency: grant in IDLE, BEATS FILL cycles, word presented the next cycle (BEATS+1 from grant).
// Backpressure: word, id and valid held in PRESENT until rsp_ready[rsp_id]; no new grant meanwhile.
//
// Ports: clk/rst (sync, active-high); req level requests; rng_enable/rng_data to the
// generator; rsp_valid (one-hot), rsp_id, rsp_data, rsp_ready response handshake;
// busy (not IDLE); health_fail (sticky stuck-source flag).
// Optional macro RNG_ARB_HEALTH_EN adds the repeated-sample health monitor; when it is
// undefined health_fail is tied low.
module rng_word_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int WORD_WIDTH  = 32,
  parameter int STUCK_LIMIT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic                       rng_enable,
  input  logic [DATA_WIDTH-1:0]      rng_data,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WORD_WIDTH-1:0]      rsp_data,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic                       busy,
  output logic                       health_fail
);

  localparam int BEATS = WORD_WIDTH / DATA_WIDTH;
  localparam int IDW   = $clog2(NUM_REQ);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 16 || (WORD_WIDTH % DATA_WIDTH) != 0 ||
      STUCK_LIMIT < 2 || STUCK_LIMIT > 255) begin : g_cfg_err
    $error("rng_word_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, FILL, PRESENT} state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        ptr_q;
  logic [IDW-1:0]        rsp_id_q;
  logic [BW-1:0]         beat_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [WORD_WIDTH-1:0] rsp_data_q;
  logic                  grant_vld;
  logic [IDW-1:0]        grant_idx;
  logic                  last_beat;
  logic                  accept;

  // First set request at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = (int'(ptr_q) + i) % NUM_REQ;
      if (!grant_vld && req[j]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(j);
      end
    end
  end

  assign last_beat = (beat_q == BW'(BEATS - 1));
  // Only the granted requester's ready bit can complete the handshake.
  assign accept    = rsp_ready[rsp_id_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld && !health_fail) state_d = FILL;
      FILL:    if (last_beat) state_d = PRESENT;
      PRESENT: if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rsp_id_q    <= '0;
      beat_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_vld && !health_fail) begin
            rsp_id_q <= grant_idx;
            beat_q   <= '0;
          end
        end
        FILL: begin
          rsp_data_q[beat_q*DATA_WIDTH +: DATA_WIDTH] <= rng_data;
          beat_q <= beat_q + BW'(1);
          if (last_beat)
            rsp_valid_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << rsp_id_q;
        end
        PRESENT: begin
          if (accept) begin
            rsp_valid_q <= '0;
            ptr_q       <= (rsp_id_q == IDW'(NUM_REQ - 1)) ? '0 : rsp_id_q + IDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Decoded from the state register only, so no input reaches the generator enable.
  assign rng_enable = (state_q == FILL);
  assign busy       = (state_q != IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;

`ifdef RNG_ARB_HEALTH_EN
  logic [DATA_WIDTH-1:0] prev_q;
  logic [7:0]            stuck_q;
  logic                  fail_q;

  // prev_q spans word boundaries so a source stuck across words is still caught.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= '0;
      stuck_q <= '0;
      fail_q  <= 1'b0;
    end else if (state_q == FILL) begin
      prev_q <= rng_data;
      if (rng_data == prev_q) begin
        if (stuck_q != 8'hFF) stuck_q <= stuck_q + 8'd1;
        if (({1'b0, stuck_q} + 9'd1) >= 9'(STUCK_LIMIT)) fail_q <= 1'b1;
      end else begin
        stuck_q <= '0;
      end
    end
  end

  assign health_fail = fail_q;
`else
  assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_rng_word_arbiter.sv
module tb_rng_word_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic        rng_enable;
  logic [7:0]  rng_data;
  logic [3:0]  rsp_valid;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_ready;
  logic        busy;
  logic        health_fail;

  // Generator stub: counts enables, or returns a constant byte.
  logic        stub_rst;
  logic        const_mode;
  logic [7:0]  en_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (stub_rst) en_cnt <= 8'd0;
    else if (rng_enable) en_cnt <= en_cnt + 8'd1;
  end

  assign rng_data = const_mode ? 8'hA5 : en_cnt;

  rng_word_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .WORD_WIDTH(32), .STUCK_LIMIT(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .rng_enable(rng_enable), .rng_data(rng_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy), .health_fail(health_fail)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stub_rst = 1'b1;
    tick(); tick();
    rst = 1'b0; stub_rst = 1'b0;
  endtask

  // Waits up to 20 cycles for a presented word; counts enable cycles on the way.
  task automatic get_word(output bit ok, output int lat, output int nen);
    ok = 1'b0; lat = 0; nen = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (rng_enable) nen++;
      if (rsp_valid != 4'b0000) begin
        ok = 1'b1; lat = i;
        break;
      end
    end
  endtask

  logic [31:0] rr_data [5];
  logic [1:0]  rr_id   [5];

  initial begin
    bit ok;
    int lat, nen, bad;

    rr_data = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 32'h13121110};
    rr_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = '0; rsp_ready = '0; const_mode = 1'b0; rst = 1'b1; stub_rst = 1'b1;

    // Reset state
    do_reset();
    check("rst_valid", rsp_valid, 0);
    check("rst_id", rsp_id, 0);
    check("rst_data", rsp_data, 0);
    check("rst_busy", busy, 0);
    check("rst_en", rng_enable, 0);
    check("rst_health", health_fail, 0);

    // Single word
    req = 4'b0001; rsp_ready = 4'b1111;
    get_word(ok, lat, nen);
    check("single_ok", ok, 1);
    check("single_lat", lat, 5);
    check("single_nen", nen, 4);
    check("single_valid", rsp_valid, 4'b0001);
    check("single_data", rsp_data, 32'h03020100);
    req = 4'b0000;
    tick();
    check("single_done_valid", rsp_valid, 0);
    check("single_done_busy", busy, 0);

    // Round-robin
    do_reset();
    req = 4'b1111; rsp_ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      get_word(ok, lat, nen);
      check("rr_ok", ok, 1);
      check("rr_lat", lat, (k == 0) ? 5 : 6);
      check("rr_id", rsp_id, rr_id[k]);
      check("rr_valid", rsp_valid, 4'b0001 << rr_id[k]);
      check("rr_data", rsp_data, rr_data[k]);
    end
    req = 4'b0000;
    tick();

    // Backpressure with ready on a non-granted index
    do_reset();
    req = 4'b0011; rsp_ready = 4'b0000;
    get_word(ok, lat, nen);
    check("bp_ok", ok, 1);
    check("bp_id", rsp_id, 0);
    bad = 0;
    rsp_ready = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid !== 4'b0001 || rsp_data !== 32'h03020100 || rng_enable !== 1'b0 ||
          rsp_id !== 2'd0 || busy !== 1'b1) bad++;
    end
    check("bp_stable", bad, 0);
    rsp_ready = 4'b0001;
    tick();
    check("bp_release_valid", rsp_valid, 0);
    rsp_ready = 4'b0010;
    get_word(ok, lat, nen);
    check("bp_next_id", rsp_id, 1);
    check("bp_next_data", rsp_data, 32'h07060504);
    req = 4'b0000;
    tick();

    // Request withdrawal after grant
    do_reset();
    req = 4'b0100; rsp_ready = 4'b0000;
    tick();
    req = 4'b0000;
    get_word(ok, lat, nen);
    check("wd_ok", ok, 1);
    check("wd_valid", rsp_valid, 4'b0100);
    check("wd_id", rsp_id, 2);
    check("wd_data", rsp_data, 32'h03020100);
    rsp_ready = 4'b0100;
    tick();
    check("wd_done_valid", rsp_valid, 0);

    // Reset during FILL beat 2; stub keeps counting so the new word is fresh
    do_reset();
    req = 4'b0001; rsp_ready = 4'b1111;
    tick(); tick(); tick();
    check("mr_in_fill", rng_enable, 1);
    rst = 1'b1;
    tick();
    check("mr_valid", rsp_valid, 0);
    check("mr_id", rsp_id, 0);
    check("mr_data", rsp_data, 0);
    check("mr_busy", busy, 0);
    check("mr_en", rng_enable, 0);
    rst = 1'b0; req = 4'b0010;
    get_word(ok, lat, nen);
    check("mr_ok", ok, 1);
    check("mr_new_id", rsp_id, 1);
    check("mr_new_valid", rsp_valid, 4'b0010);
    check("mr_new_data", rsp_data, 32'h06050403);
    req = 4'b0000;
    tick();

    // Health monitor with a stuck source
    do_reset();
    const_mode = 1'b1; req = 4'b0001; rsp_ready = 4'b0001;
`ifdef RNG_ARB_HEALTH_EN
    for (int k = 0; k < 5; k++) begin
      get_word(ok, lat, nen);
      check("hl_ok", ok, 1);
      check("hl_data", rsp_data, 32'hA5A5A5A5);
      check("hl_flag", health_fail, (k == 4) ? 1 : 0);
    end
    get_word(ok, lat, nen);
    check("hl_no_grant", ok, 0);
    check("hl_idle", busy, 0);
    check("hl_sticky", health_fail, 1);
`else
    for (int k = 0; k < 6; k++) begin
      get_word(ok, lat, nen);
      check("hl_ok", ok, 1);
      check("hl_data", rsp_data, 32'hA5A5A5A5);
    end
    check("hl_flag", health_fail, 0);
`endif
    req = 4'b0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rng_word_arbiter.md
# rng_word_arbiter

Round-robin arbiter that shares one `rng_stream` PRBS generator between `NUM_REQ` requesters. It sequences the generator's `enable` to collect `WORD_WIDTH/DATA_WIDTH` consecutive samples and packs them into one word. It returns the word to the granted requester over a valid/ready handshake. It sits between `rng_stream` and the TPM command engines that consume random words (nonces, key seeds).

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; range 2..16.
- `DATA_WIDTH`, 8: width of `rng_data`; must equal the generator's `DATA_WIDTH`.
- `WORD_WIDTH`, 32: returned word width; must be an integer multiple of `DATA_WIDTH`. `BEATS = WORD_WIDTH/DATA_WIDTH`.
- `STUCK_LIMIT`, 16: consecutive repeated samples that trip the health monitor; range 2..255.

Ports:
- `clk`  in  1: clock; one clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  `NUM_REQ`: level request per requester.
- `rng_enable`  out  1: drives generator `enable`.
- `rng_data`  in  `DATA_WIDTH`: generator `data_out`, combinational from its current state.
- `rsp_valid`  out  `NUM_REQ`: one-hot; the bit for the granted requester is set while the word is presented.
- `rsp_id`  out  `$clog2(NUM_REQ)`: index of the granted requester.
- `rsp_data`  out  `WORD_WIDTH`: packed word.
- `rsp_ready`  in  `NUM_REQ`: per-requester accept.
- `busy`  out  1: high in every state except IDLE.
- `health_fail`  out  1: sticky stuck-source flag.

## Operation
- State machine states: IDLE, FILL, PRESENT. Reset enters IDLE.
- Round-robin pointer `ptr`, reset to 0.
- **IDLE:**
  - If any `req` bit is set and `health_fail` = 0, grant the first set bit searching upward from `ptr` modulo `NUM_REQ`.
  - Latch the grant into `rsp_id`, clear the beat counter, go to FILL.
- **FILL:**
  - `rng_enable` = 1 every cycle.
  - Each cycle, sample `rng_data` into `rsp_data[beat*DATA_WIDTH +: DATA_WIDTH]`; beat 0 lands in the LSBs.
  - After beat `BEATS-1`, go to PRESENT.
  - Exactly `BEATS` enables are issued per word.
- **PRESENT:**
  - `rng_enable` = 0.
  - `rsp_valid[rsp_id]` = 1; `rsp_data` and `rsp_id` are held stable.
  - On `rsp_ready[rsp_id]` = 1, set `ptr` = (`rsp_id`+1) mod `NUM_REQ` and go to IDLE.
  - `rsp_ready` bits of non-granted requesters are ignored.
- `req` is sampled only in IDLE. Deasserting it after the grant does not cancel the transaction; the word is still presented and held until accepted.
- Each packed word comes from fresh samples; samples are never reused across words.
- **Reset mid-operation:** returns to IDLE next cycle. The partial word is discarded, `ptr` = 0, all outputs go to reset values.
- **Reset values:** `rng_enable` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_data` 0, `busy` 0, `health_fail` 0.

## Timing
- Grant cycle T (IDLE with a request present): FILL occupies cycles T+1..T+BEATS.
- `rsp_valid` rises at cycle T+BEATS+1.
- Minimum request-to-valid latency is `BEATS`+1 cycles (5 at defaults).
- Handshake at cycle H: `rsp_valid` is 0 at H+1 (IDLE). The next grant can occur at H+1, so its FILL starts at H+2.
- Peak throughput is one word per `BEATS`+2 cycles.
- All outputs are registered except `rng_enable`, which is decoded from the state register only (no combinational path from inputs).

## Configuration
- Macro `RNG_ARB_HEALTH_EN`.
- **Defined:**
  - A counter tracks consecutive FILL samples equal to the previous FILL sample. The previous sample persists across words and resets to 0.
  - A mismatch clears the counter.
  - When the counter reaches `STUCK_LIMIT`, `health_fail` sets and stays set until `rst`.
  - The in-flight word still completes and is presented normally.
  - No new grants are issued while `health_fail` = 1.
- **Undefined:** `health_fail` is tied to 0; no counter or compare logic is present.

## Test plan
- **Single word:** stub `rng_data` = count of enables seen (0,1,2,…); `req`=4'b0001; `rsp_ready` high → `rsp_valid`=4'b0001 at grant+5, `rsp_data`=32'h03020100, exactly 4 `rng_enable` cycles.
- **Round-robin:** `req`=4'b1111 held, `rsp_ready` all high → grant order 0,1,2,3,0. Words 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C; one word every 6 cycles.
- **Backpressure:** `rsp_ready`=0 for 20 cycles during PRESENT → `rsp_valid`, `rsp_data` stable, `rng_enable`=0, other requests not granted. `rsp_ready` asserted on a non-granted index → ignored.
- **Request withdrawal:** `req[2]` drops one cycle after grant → word still delivered with `rsp_valid`=4'b0100 and `rsp_id`=2.
- **Reset mid-FILL:** `rst` at beat 2 → next cycle all outputs 0, `busy`=0. A following `req`=4'b0010 is granted and starts a fresh word.
- **Health (`RNG_ARB_HEALTH_EN` defined, `STUCK_LIMIT`=16):** constant `rng_data`=8'hA5 → `health_fail` sets during the fifth word. That word is delivered; subsequent requests get no grant. With the macro undefined → `health_fail` stays 0 and grants continue.
